arc4_key_search_ctrl: RTL and testbench

- Brute-force key-search scheduler around one arc4 decryptor.
- Steps candidate keys and starts arc4 through its en/rdy handshake for each one.
- After each decrypt, takes ownership of the pt_mem port and scans the plaintext for printable ASCII.
- Reports the first key that yields an all-printable message, or reports exhaustion.

---
 rtl/arc4_search_pkg.sv | 24 ++
 rtl/arc4_pt_checker.sv | 89 ++++++++
 rtl/arc4_key_search_ctrl.sv | 177 +++++++++++++++++
 tb/tb_arc4_key_search_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_search_pkg.sv
// Shared types and constants for the arc4 brute-force key search controller.
package arc4_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_A4,
    RD_LEN,
    LEN_LAT,
    CHK,
    NEXT,
    FOUND
  } state_t;

  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;
  localparam logic [7:0] LEN_ADDR  = 8'h00;

  // A byte is acceptable plaintext when it is a printable ASCII character.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/arc4_pt_checker.sv
// Plaintext scanner: reads the length byte, then streams bytes 1..L from the
// synchronous-read pt_mem at one byte per cycle and flags pass/fail with a
// single-cycle done strobe. It follows the controller state rather than
// keeping its own copy of the sequence.
module arc4_pt_checker
  import arc4_search_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  state_t     i_state,
  input  logic [7:0] i_rddata,
  output logic [7:0] o_addr,
  output logic       o_done,
  output logic       o_pass
);

  logic [7:0] r_addr;
  logic [7:0] r_len;
  logic [7:0] r_rdIdx;
  logic       r_rdValid;
  logic       r_allIssued;

  // Address generation and read-pipeline tracking; the address stops at L so
  // nothing past the message end is ever read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 8'h00;
      r_len       <= 8'h00;
      r_rdIdx     <= 8'h00;
      r_rdValid   <= 1'b0;
      r_allIssued <= 1'b0;
    end else begin
      case (i_state)
        RD_LEN: begin
          r_addr      <= LEN_ADDR;
          r_rdValid   <= 1'b0;
          r_allIssued <= 1'b0;
        end
        LEN_LAT: begin
          r_len       <= i_rddata;
          r_addr      <= 8'h01;
          r_rdValid   <= 1'b0;
          r_allIssued <= 1'b0;
        end
        CHK: begin
          r_rdValid <= !r_allIssued;
          r_rdIdx   <= r_addr;
          if (r_addr == r_len) begin
            r_allIssued <= 1'b1;
          end else begin
            r_addr <= r_addr + 8'h01;
          end
        end
        default: begin
          r_rdValid <= 1'b0;
        end
      endcase
    end
  end

  // Verdict: an empty message passes immediately, a non-printable byte fails
  // at once, and the last byte being printable passes.
  always_comb begin
    o_done = 1'b0;
    o_pass = 1'b0;
    case (i_state)
      LEN_LAT: begin
        if (i_rddata == 8'h00) begin
          o_done = 1'b1;
          o_pass = 1'b1;
        end
      end
      CHK: begin
        if (r_rdValid) begin
          if (!is_printable(i_rddata)) begin
            o_done = 1'b1;
          end else if (r_rdIdx == r_len) begin
            o_done = 1'b1;
            o_pass = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_addr = (i_state == RD_LEN) ? LEN_ADDR : r_addr;

endmodule

// File: rtl/arc4_key_search_ctrl.sv
// Brute-force key search scheduler around one arc4 decryptor. Steps candidate
// keys, starts arc4 for each, then takes over pt_mem to scan the plaintext.
// Optional candidate counter on output tries: define ARC4_KEY_SEARCH_TRIES_EN.
module arc4_key_search_ctrl
  import arc4_search_pkg::*;
#(
  parameter int          KEY_W     = 24,
  parameter int unsigned KEY_START = 0,
  parameter int unsigned KEY_STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic [31:0]      tries,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [KEY_W-1:0] a4_key,
  input  logic [7:0]       a4_pt_addr,
  input  logic [7:0]       a4_pt_wrdata,
  input  logic             a4_pt_wren,
  output logic [7:0]       pt_addr,
  output logic [7:0]       pt_wrdata,
  output logic             pt_wren,
  input  logic [7:0]       pt_rddata
);

  localparam int               KW1     = KEY_W + 1;
  localparam logic [KEY_W-1:0] W_START = KEY_W'(KEY_START);
  localparam logic [KEY_W:0]   W_STEP  = KW1'(KEY_STEP);

  state_t           r_state;
  state_t           w_nextState;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] r_key;
  logic             r_keyValid;
  logic             r_waitFirst;
  logic [KEY_W:0]   w_candSum;
  logic             w_lastCand;
  logic [7:0]       w_chkAddr;
  logic             w_chkDone;
  logic             w_chkPass;
  logic             w_passThru;

  // The carry out of the widened sum means the next candidate would exceed
  // the key range, so the current one is the last.
  assign w_candSum  = {1'b0, r_cand} + W_STEP;
  assign w_lastCand = w_candSum[KEY_W];

  arc4_pt_checker u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_state  (r_state),
    .i_rddata (pt_rddata),
    .o_addr   (w_chkAddr),
    .o_done   (w_chkDone),
    .o_pass   (w_chkPass)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the arc4 start strobe.
  always_comb begin
    w_nextState = r_state;
    a4_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_nextState = START;
      end
      START: begin
        if (a4_rdy) begin
          a4_en       = 1'b1;
          w_nextState = WAIT_A4;
        end
      end
      WAIT_A4: begin
        if (!r_waitFirst && a4_rdy) w_nextState = RD_LEN;
      end
      RD_LEN: begin
        w_nextState = LEN_LAT;
      end
      LEN_LAT, CHK: begin
        if (w_chkDone) begin
          w_nextState = w_chkPass ? FOUND : NEXT;
        end else begin
          w_nextState = CHK;
        end
      end
      NEXT: begin
        w_nextState = w_lastCand ? IDLE : START;
      end
      FOUND: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Candidate stepping, result capture and the arc4 drop-out mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand      <= '0;
      r_key       <= '0;
      r_keyValid  <= 1'b0;
      r_waitFirst <= 1'b0;
    end else begin
      r_waitFirst <= (r_state == START) && a4_rdy;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_keyValid <= 1'b0;
            r_key      <= '0;
            r_cand     <= W_START;
          end
        end
        NEXT: begin
          if (!w_lastCand) r_cand <= w_candSum[KEY_W-1:0];
        end
        FOUND: begin
          r_key      <= r_cand;
          r_keyValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARC4_KEY_SEARCH_TRIES_EN
  logic [31:0] r_tries;

  // Saturating count of candidates fully evaluated in this search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tries <= 32'h0;
    end else if ((r_state == IDLE) && en) begin
      r_tries <= 32'h0;
    end else if (((r_state == NEXT) || (r_state == FOUND)) && (r_tries != 32'hFFFF_FFFF)) begin
      r_tries <= r_tries + 32'h1;
    end
  end

  assign tries = r_tries;
`else
  assign tries = 32'h0;
`endif

  // arc4 owns pt_mem until it reports done; afterwards the checker reads it.
  always_comb begin
    w_passThru = (r_state == IDLE) || (r_state == START) || (r_state == WAIT_A4);
    if (w_passThru) begin
      pt_addr   = a4_pt_addr;
      pt_wrdata = a4_pt_wrdata;
      pt_wren   = a4_pt_wren;
    end else begin
      pt_addr   = w_chkAddr;
      pt_wrdata = 8'h00;
      pt_wren   = 1'b0;
    end
  end

  assign rdy       = (r_state == IDLE);
  assign key_valid = r_keyValid;
  assign key       = r_key;
  assign a4_key    = r_cand;

endmodule

// File: tb/tb_arc4_key_search_ctrl.sv
// Self-checking bench for arc4_key_search_ctrl: a 24-bit instance with a
// behavioural arc4 + pt_mem model, plus a 4-bit instance for exhaustion.
module tb_arc4_key_search_ctrl;

  localparam int M_HI = 0, M_NONE = 1, M_EMPTY = 2, M_STALE = 3, M_BOUND = 4;
`ifdef ARC4_KEY_SEARCH_TRIES_EN
  localparam int TE = 1;
`else
  localparam int TE = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mode = M_HI;

  // 24-bit instance signals
  logic en = 1'b0, rdy, key_valid, a4_en, a4_rdy, a4_pt_wren, pt_wren;
  logic [23:0] key, a4_key;
  logic [31:0] tries;
  logic [7:0]  a4_pt_addr, a4_pt_wrdata, pt_addr, pt_wrdata, pt_rddata;

  // 4-bit instance signals
  logic en4 = 1'b0, rdy4, key_valid4, a4_en4, a4_rdy4, a4_pt_wren4, pt_wren4;
  logic [3:0]  key4, a4_key4;
  logic [31:0] tries4;
  logic [7:0]  a4_pt_addr4, a4_pt_wrdata4, pt_addr4, pt_wrdata4, pt_rddata4;

  arc4_key_search_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key_valid(key_valid), .key(key),
    .tries(tries), .a4_en(a4_en), .a4_rdy(a4_rdy), .a4_key(a4_key),
    .a4_pt_addr(a4_pt_addr), .a4_pt_wrdata(a4_pt_wrdata), .a4_pt_wren(a4_pt_wren),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren), .pt_rddata(pt_rddata)
  );

  arc4_key_search_ctrl #(.KEY_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .rdy(rdy4), .key_valid(key_valid4), .key(key4),
    .tries(tries4), .a4_en(a4_en4), .a4_rdy(a4_rdy4), .a4_key(a4_key4),
    .a4_pt_addr(a4_pt_addr4), .a4_pt_wrdata(a4_pt_wrdata4), .a4_pt_wren(a4_pt_wren4),
    .pt_addr(pt_addr4), .pt_wrdata(pt_wrdata4), .pt_wren(pt_wren4), .pt_rddata(pt_rddata4)
  );

  // Plaintext the behavioural arc4 writes at pt_mem[0..4] for a given key.
  function automatic logic [7:0] content(input int md, input logic [23:0] k, input int idx);
    logic [7:0] b [5];
    b = '{8'h03, 8'h01, 8'h01, 8'h01, 8'h01};
    case (md)
      M_HI: begin
        if (k == 24'd5)      b = '{8'h03, 8'h48, 8'h69, 8'h21, 8'h01};
        else if (k == 24'd2) b = '{8'h03, 8'h61, 8'h7F, 8'h62, 8'h01};
        else if (k == 24'd3) b = '{8'h03, 8'h20, 8'h7E, 8'h1F, 8'h01};
      end
      M_EMPTY: if (k == 24'd0) b[0] = 8'h00;
      M_STALE: if (k == 24'd0) b = '{8'h02, 8'h4F, 8'h4B, 8'h01, 8'h01};
      M_BOUND: begin
        if (k == 24'd0)      b[1] = 8'h1F;
        else if (k == 24'd1) b = '{8'h03, 8'h20, 8'h7E, 8'h7E, 8'h01};
      end
      default: ;
    endcase
    return b[idx];
  endfunction

  // Behavioural arc4 for the 24-bit instance: keeps rdy high one cycle after
  // en, then writes five bytes and raises rdy again.
  logic m_rdy, m_pend, m_wren;
  int m_cnt;
  logic [23:0] m_key;
  logic [7:0] m_addr, m_data;
  assign a4_rdy = m_rdy;
  assign a4_pt_addr = m_addr;
  assign a4_pt_wrdata = m_data;
  assign a4_pt_wren = m_wren;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b1; m_pend <= 1'b0; m_cnt <= 0; m_key <= '0;
      m_addr <= '0; m_data <= '0; m_wren <= 1'b0;
    end else begin
      m_wren <= 1'b0; m_addr <= '0; m_data <= '0;
      if (m_pend) begin
        m_pend <= 1'b0; m_rdy <= 1'b0; m_cnt <= 0;
      end else if (a4_en && m_rdy) begin
        m_pend <= 1'b1; m_key <= a4_key;
      end else if (!m_rdy) begin
        if (m_cnt < 5) begin
          m_wren <= 1'b1; m_addr <= 8'(m_cnt); m_data <= content(mode, m_key, m_cnt);
        end
        if (m_cnt == 6) m_rdy <= 1'b1;
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (pt_wren) mem[pt_addr] <= pt_wrdata;
    pt_rddata <= mem[pt_addr];
  end

  // Same model for the 4-bit instance; every key gives non-printable text.
  logic n_rdy, n_pend, n_wren;
  int n_cnt;
  logic [7:0] n_addr, n_data;
  assign a4_rdy4 = n_rdy;
  assign a4_pt_addr4 = n_addr;
  assign a4_pt_wrdata4 = n_data;
  assign a4_pt_wren4 = n_wren;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_rdy <= 1'b1; n_pend <= 1'b0; n_cnt <= 0;
      n_addr <= '0; n_data <= '0; n_wren <= 1'b0;
    end else begin
      n_wren <= 1'b0; n_addr <= '0; n_data <= '0;
      if (n_pend) begin
        n_pend <= 1'b0; n_rdy <= 1'b0; n_cnt <= 0;
      end else if (a4_en4 && n_rdy) begin
        n_pend <= 1'b1;
      end else if (!n_rdy) begin
        if (n_cnt < 5) begin
          n_wren <= 1'b1; n_addr <= 8'(n_cnt); n_data <= content(M_NONE, 24'd0, n_cnt);
        end
        if (n_cnt == 6) n_rdy <= 1'b1;
        n_cnt <= n_cnt + 1;
      end
    end
  end

  logic [7:0] mem4 [256];
  always @(posedge clk) begin
    if (pt_wren4) mem4[pt_addr4] <= pt_wrdata4;
    pt_rddata4 <= mem4[pt_addr4];
  end

  // Observers of the arc4 start strobe and of the checker's address range.
  int pulses = 0, orderErr = 0, doubleErr = 0, addr3Seen = 0;
  logic [23:0] lastKey = '0, firstKey = '0;
  logic prevEn = 1'b0;
  int pulses4 = 0, orderErr4 = 0, doubleErr4 = 0;
  logic [3:0] lastKey4 = '0, firstKey4 = '0;
  logic prevEn4 = 1'b0;

  always @(negedge clk) begin
    if (a4_en) begin
      if (pulses > 0 && a4_key <= lastKey) orderErr++;
      if (pulses == 0) firstKey = a4_key;
      lastKey = a4_key;
      pulses++;
    end
    if (a4_en && prevEn) doubleErr++;
    prevEn = a4_en;
    if (pt_addr == 8'd3 && m_rdy && !m_pend && !rdy) addr3Seen++;
    if (a4_en4) begin
      if (pulses4 > 0 && a4_key4 <= lastKey4) orderErr4++;
      if (pulses4 == 0) firstKey4 = a4_key4;
      lastKey4 = a4_key4;
      pulses4++;
    end
    if (a4_en4 && prevEn4) doubleErr4++;
    prevEn4 = a4_en4;
  end

  task automatic clear_mon;
    pulses = 0; orderErr = 0; doubleErr = 0; addr3Seen = 0;
    pulses4 = 0; orderErr4 = 0; doubleErr4 = 0;
  endtask

  task automatic start_search;
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic wait_rdy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rdy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy: got %0b expected 1", rdy); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_valid: got %0b expected 0", key_valid); end
    checks++; if (key !== 24'h0) begin failures++; $display("[TB] FAIL reset_key: got %0h expected 0", key); end
    checks++; if (a4_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_a4_en: got %0b expected 0", a4_en); end
    checks++; if (a4_key !== 24'h0) begin failures++; $display("[TB] FAIL reset_a4_key: got %0h expected 0", a4_key); end
    checks++; if (tries !== 32'h0) begin failures++; $display("[TB] FAIL reset_tries: got %0d expected 0", tries); end
    checks++; if (pt_wren !== 1'b0) begin failures++; $display("[TB] FAIL reset_pt_wren: got %0b expected 0", pt_wren); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_find_key;
    bit ok;
    mode = M_HI; clear_mon();
    start_search();
    checks++; if (rdy !== 1'b0) begin failures++; $display("[TB] FAIL find_rdy_drop: got %0b expected 0", rdy); end
    wait_rdy(2000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL find_timeout: got no rdy expected rdy within budget"); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("[TB] FAIL find_valid: got %0b expected 1", key_valid); end
    checks++; if (key !== 24'h000005) begin failures++; $display("[TB] FAIL find_key: got %0h expected 5", key); end
    checks++; if (tries !== 32'(TE * 6)) begin failures++; $display("[TB] FAIL find_tries: got %0d expected %0d", tries, TE * 6); end
    checks++; if (pulses != 6) begin failures++; $display("[TB] FAIL find_pulses: got %0d expected 6", pulses); end
    checks++; if (doubleErr != 0) begin failures++; $display("[TB] FAIL find_a4_en_width: got %0d long pulses expected 0", doubleErr); end
    repeat (5) @(negedge clk);
    checks++; if (key_valid !== 1'b1 || key !== 24'h5) begin failures++; $display("[TB] FAIL find_hold: got valid=%0b key=%0h expected valid=1 key=5", key_valid, key); end
  endtask

  task automatic test_boundary;
    bit ok;
    mode = M_BOUND; clear_mon();
    start_search();
    checks++; if (key_valid !== 1'b0 || key !== 24'h0) begin failures++; $display("[TB] FAIL start_clear: got valid=%0b key=%0h expected valid=0 key=0", key_valid, key); end
    wait_rdy(2000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL bound_timeout: got no rdy expected rdy within budget"); end
    checks++; if (key_valid !== 1'b1 || key !== 24'h1) begin failures++; $display("[TB] FAIL bound_key: got valid=%0b key=%0h expected valid=1 key=1", key_valid, key); end
    checks++; if (tries !== 32'(TE * 2)) begin failures++; $display("[TB] FAIL bound_tries: got %0d expected %0d", tries, TE * 2); end
  endtask

  task automatic test_exhaust;
    bit ok;
    clear_mon();
    @(negedge clk); en4 = 1'b1;
    @(negedge clk); en4 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rdy4) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("[TB] FAIL exh_timeout: got no rdy expected rdy within budget"); end
    checks++; if (key_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL exh_valid: got %0b expected 0", key_valid4); end
    checks++; if (pulses4 != 16) begin failures++; $display("[TB] FAIL exh_pulses: got %0d expected 16", pulses4); end
    checks++; if (orderErr4 != 0 || doubleErr4 != 0) begin failures++; $display("[TB] FAIL exh_order: got order=%0d double=%0d expected 0 0", orderErr4, doubleErr4); end
    checks++; if (firstKey4 !== 4'd0 || lastKey4 !== 4'd15) begin failures++; $display("[TB] FAIL exh_range: got %0d..%0d expected 0..15", firstKey4, lastKey4); end
    checks++; if (tries4 !== 32'(TE * 16)) begin failures++; $display("[TB] FAIL exh_tries: got %0d expected %0d", tries4, TE * 16); end
  endtask

  task automatic test_empty;
    bit ok;
    mode = M_EMPTY; clear_mon();
    start_search();
    wait_rdy(2000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL empty_timeout: got no rdy expected rdy within budget"); end
    checks++; if (key_valid !== 1'b1 || key !== 24'h0) begin failures++; $display("[TB] FAIL empty_key: got valid=%0b key=%0h expected valid=1 key=0", key_valid, key); end
    checks++; if (pulses != 1) begin failures++; $display("[TB] FAIL empty_pulses: got %0d expected 1", pulses); end
    checks++; if (tries !== 32'(TE)) begin failures++; $display("[TB] FAIL empty_tries: got %0d expected %0d", tries, TE); end
  endtask

  task automatic test_stale;
    bit ok;
    mode = M_STALE; clear_mon();
    start_search();
    wait_rdy(2000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL stale_timeout: got no rdy expected rdy within budget"); end
    checks++; if (key_valid !== 1'b1 || key !== 24'h0) begin failures++; $display("[TB] FAIL stale_key: got valid=%0b key=%0h expected valid=1 key=0", key_valid, key); end
    checks++; if (addr3Seen != 0) begin failures++; $display("[TB] FAIL stale_addr: got %0d reads of addr 3 expected 0", addr3Seen); end
  endtask

  task automatic test_en_held;
    bit ok;
    mode = M_HI; clear_mon();
    @(negedge clk); en = 1'b1;
    wait_rdy(2000, ok);
    en = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL held_timeout: got no rdy expected rdy within budget"); end
    checks++; if (pulses != 6) begin failures++; $display("[TB] FAIL held_pulses: got %0d expected 6", pulses); end
    checks++; if (orderErr != 0 || doubleErr != 0) begin failures++; $display("[TB] FAIL held_order: got order=%0d double=%0d expected 0 0", orderErr, doubleErr); end
    checks++; if (key_valid !== 1'b1 || key !== 24'h5) begin failures++; $display("[TB] FAIL held_key: got valid=%0b key=%0h expected valid=1 key=5", key_valid, key); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    mode = M_NONE; clear_mon();
    start_search();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pt_addr == 8'd1 && m_rdy && !m_pend && !rdy) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL mid_reach_chk: got no scan expected scan within budget"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rdy !== 1'b1) begin failures++; $display("[TB] FAIL mid_rdy: got %0b expected 1", rdy); end
    checks++; if (key_valid !== 1'b0 || pt_wren !== 1'b0 || a4_en !== 1'b0) begin failures++; $display("[TB] FAIL mid_outputs: got valid=%0b wren=%0b a4_en=%0b expected 0 0 0", key_valid, pt_wren, a4_en); end
    @(negedge clk); rst_n = 1'b1;
    mode = M_HI; clear_mon();
    start_search();
    wait_rdy(2000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_timeout: got no rdy expected rdy within budget"); end
    checks++; if (firstKey !== 24'h0) begin failures++; $display("[TB] FAIL mid_restart: got first key %0h expected 0", firstKey); end
    checks++; if (key_valid !== 1'b1 || key !== 24'h5) begin failures++; $display("[TB] FAIL mid_key: got valid=%0b key=%0h expected valid=1 key=5", key_valid, key); end
  endtask

  initial begin
    $display("[TB] arc4_key_search_ctrl bench start");
    test_reset();
    test_find_key();
    test_boundary();
    test_exhaust();
    test_empty();
    test_stale();
    test_en_held();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
